// File: rtl/shifter_arbiter_pkg.sv
// Shared constants for the two-requester rotate arbiter: requester IDs,
// result-stage state encoding and the statistics counter width.
package shifter_arbiter_pkg;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  localparam int unsigned STAT_W = 16;

endpackage

// File: rtl/rotr_core.sv
// Combinational right rotate. Port shape matches the barrel shifter so the
// two are interchangeable at the datapath level.
module rotr_core #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0]         in,
  input  logic [$clog2(DATA_W)-1:0] ctrl,
  output logic [DATA_W-1:0]         out
);

  localparam int unsigned AMT_W = $clog2(DATA_W);

  logic [AMT_W:0] lshift;

  // Rotate = logical right shift OR'd with the wrapped-around low bits;
  // ctrl=0 gives a left shift of DATA_W, which contributes nothing.
  always_comb begin
    lshift = (AMT_W+1)'(DATA_W) - {1'b0, ctrl};
    out    = (in >> ctrl) | (in << lshift);
  end

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin arbiter sharing one rotr_core between two valid/ready
// requesters, with a single registered, ID-tagged result stage.
// Optional statistics counters enabled by defining SHIFTER_ARBITER_STATS_EN.
module shifter_arbiter
  import shifter_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned RR_INIT = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [DATA_W-1:0]         req0_data,
  input  logic [$clog2(DATA_W)-1:0] req0_amt,
  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [DATA_W-1:0]         req1_data,
  input  logic [$clog2(DATA_W)-1:0] req1_amt,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [DATA_W-1:0]         resp_data,
  output logic                      resp_id
`ifdef SHIFTER_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0]         gnt0_cnt,
  output logic [STAT_W-1:0]         gnt1_cnt,
  output logic [STAT_W-1:0]         stall_cnt
`endif
);

  localparam int unsigned AMT_W = $clog2(DATA_W);

  logic              state;
  logic              last_grant;
  logic              can_accept;
  logic              grant0;
  logic              grant1;
  logic              xfer;
  logic              sel;
  logic [DATA_W-1:0] mux_data;
  logic [AMT_W-1:0]  mux_amt;
  logic [DATA_W-1:0] rot_data;

  assign resp_valid = (state == ST_FULL);
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Grant decision: readies are held low during reset even though the
  // result stage already reads EMPTY under the asynchronous clear.
  always_comb begin
    can_accept = ~rst & ((state == ST_EMPTY) | resp_ready);
    grant0     = can_accept & req0_valid & (~req1_valid | (last_grant == REQ1));
    grant1     = can_accept & req1_valid & (~req0_valid | (last_grant == REQ0));
    xfer       = grant0 | grant1;
    sel        = grant1 ? REQ1 : REQ0;
    mux_data   = grant1 ? req1_data : req0_data;
    mux_amt    = grant1 ? req1_amt  : req0_amt;
  end

  rotr_core #(.DATA_W(DATA_W)) u_rotr (
    .in   (mux_data),
    .ctrl (mux_amt),
    .out  (rot_data)
  );

  // Result stage: load on transfer, drop valid on drain, hold on stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_EMPTY;
      resp_data  <= '0;
      resp_id    <= REQ0;
      last_grant <= (RR_INIT == 0) ? REQ1 : REQ0;
    end else if (xfer) begin
      state      <= ST_FULL;
      resp_data  <= rot_data;
      resp_id    <= sel;
      last_grant <= sel;
    end else if ((state == ST_FULL) && resp_ready) begin
      state      <= ST_EMPTY;
    end
  end

`ifdef SHIFTER_ARBITER_STATS_EN
  // Saturating per-requester grant counters and output stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt0_cnt  <= '0;
      gnt1_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (grant0 && (gnt0_cnt != '1))
        gnt0_cnt <= gnt0_cnt + 1'b1;
      if (grant1 && (gnt1_cnt != '1))
        gnt1_cnt <= gnt1_cnt + 1'b1;
      if (resp_valid && !resp_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level reference model.
module tb_shifter_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic [2:0] req0_amt, req1_amt;
  logic       resp_valid, resp_ready, resp_id;
  logic [7:0] resp_data;
`ifdef SHIFTER_ARBITER_STATS_EN
  logic [15:0] gnt0_cnt, gnt1_cnt, stall_cnt;
`endif

  int unsigned pass_cnt = 0;
  int unsigned total_cnt = 0;

  // Reference model: pending result register and last winner.
  logic       m_valid, m_id, m_last;
  logic [7:0] m_data;
  logic       exp_r0, exp_r1;
  logic       obs_r0, obs_r1;

  always #5 clk = ~clk;

  shifter_arbiter #(.DATA_W(8), .RR_INIT(0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id)
`ifdef SHIFTER_ARBITER_STATS_EN
    ,
    .gnt0_cnt   (gnt0_cnt),
    .gnt1_cnt   (gnt1_cnt),
    .stall_cnt  (stall_cnt)
`endif
  );

  // Bit i of a right rotate comes from bit (i+amt) mod 8 of the operand.
  function automatic logic [7:0] rot_ref(input logic [7:0] d, input int unsigned amt);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = d[(i + amt) % 8];
    return r;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00; m_id = 1'b0; m_last = 1'b1;
  endtask

  // Predicts this cycle's readies and advances the model across the edge.
  task automatic model_step(input logic v0, input logic [7:0] d0, input logic [2:0] a0,
                            input logic v1, input logic [7:0] d1, input logic [2:0] a1,
                            input logic rr);
    logic can;
    can = !m_valid || rr;
    exp_r0 = 1'b0; exp_r1 = 1'b0;
    if (can) begin
      if (v0 && v1) begin
        if (m_last) exp_r0 = 1'b1; else exp_r1 = 1'b1;
      end else if (v0) exp_r0 = 1'b1;
      else if (v1) exp_r1 = 1'b1;
    end
    if (exp_r0) begin m_valid = 1'b1; m_data = rot_ref(d0, a0); m_id = 1'b0; m_last = 1'b0; end
    else if (exp_r1) begin m_valid = 1'b1; m_data = rot_ref(d1, a1); m_id = 1'b1; m_last = 1'b1; end
    else if (rr) m_valid = 1'b0;
  endtask

  // Drives one cycle of stimulus, captures readies before the edge and
  // returns #1 after the edge so registered outputs can be sampled.
  task automatic drive_cycle(input logic v0, input logic [7:0] d0, input logic [2:0] a0,
                             input logic v1, input logic [7:0] d1, input logic [2:0] a1,
                             input logic rr);
    req0_valid = v0; req0_data = d0; req0_amt = a0;
    req1_valid = v1; req1_data = d1; req1_amt = a1;
    resp_ready = rr;
    #1;
    obs_r0 = req0_ready; obs_r1 = req1_ready;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
    req0_data = '0; req1_data = '0; req0_amt = '0; req1_amt = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    total_cnt++; if (resp_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", resp_valid); else pass_cnt++;
    total_cnt++; if (resp_data !== 8'h00) $display("FAIL reset_data got=%h exp=00", resp_data); else pass_cnt++;
    total_cnt++; if (resp_id !== 1'b0) $display("FAIL reset_id got=%b exp=0", resp_id); else pass_cnt++;
    total_cnt++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); else pass_cnt++;
    do_reset();
  endtask

  task automatic test_single_ops();
    logic       id_l [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] dat_l [4] = '{8'h80, 8'h81, 8'hFF, 8'hA5};
    logic [2:0] amt_l [4] = '{3'd4, 3'd1, 3'd7, 3'd0};
    logic [7:0] exp_l [4] = '{8'h08, 8'hC0, 8'hFF, 8'hA5};
    for (int k = 0; k < 4; k++) begin
      model_step(!id_l[k], dat_l[k], amt_l[k], id_l[k], dat_l[k], amt_l[k], 1'b1);
      drive_cycle(!id_l[k], dat_l[k], amt_l[k], id_l[k], dat_l[k], amt_l[k], 1'b1);
      total_cnt++; if ({obs_r1, obs_r0} !== (id_l[k] ? 2'b10 : 2'b01)) $display("FAIL single_ready[%0d] got=%b exp=%b", k, {obs_r1, obs_r0}, id_l[k] ? 2'b10 : 2'b01); else pass_cnt++;
      total_cnt++; if (resp_valid !== 1'b1) $display("FAIL single_valid[%0d] got=%b exp=1", k, resp_valid); else pass_cnt++;
      total_cnt++; if (resp_data !== exp_l[k]) $display("FAIL single_data[%0d] got=%h exp=%h", k, resp_data, exp_l[k]); else pass_cnt++;
      total_cnt++; if (resp_id !== id_l[k]) $display("FAIL single_id[%0d] got=%b exp=%b", k, resp_id, id_l[k]); else pass_cnt++;
    end
    model_step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    total_cnt++; if (resp_valid !== 1'b0) $display("FAIL drain_valid got=%b exp=0", resp_valid); else pass_cnt++;
    total_cnt++; if (resp_data !== 8'hA5) $display("FAIL drain_hold got=%h exp=a5", resp_data); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] d0, d1;
    logic [2:0] a0, a1;
    logic       exp_id;
    do_reset();
    exp_id = 1'b0;
    for (int k = 0; k < 10; k++) begin
      d0 = 8'($urandom); d1 = 8'($urandom); a0 = 3'($urandom); a1 = 3'($urandom);
      model_step(1'b1, d0, a0, 1'b1, d1, a1, 1'b1);
      drive_cycle(1'b1, d0, a0, 1'b1, d1, a1, 1'b1);
      total_cnt++; if ({obs_r1, obs_r0} !== (exp_id ? 2'b10 : 2'b01)) $display("FAIL rr_ready[%0d] got=%b exp=%b", k, {obs_r1, obs_r0}, exp_id ? 2'b10 : 2'b01); else pass_cnt++;
      total_cnt++; if (resp_id !== exp_id || resp_valid !== 1'b1) $display("FAIL rr_id[%0d] got=%b/%b exp=%b/1", k, resp_id, resp_valid, exp_id); else pass_cnt++;
      total_cnt++; if (resp_data !== (exp_id ? rot_ref(d1, a1) : rot_ref(d0, a0))) $display("FAIL rr_data[%0d] got=%h exp=%h", k, resp_data, m_data); else pass_cnt++;
      exp_id = ~exp_id;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held_d;
    logic       held_id;
    do_reset();
    model_step(1'b1, 8'h3C, 3'd2, 1'b0, '0, '0, 1'b1);
    drive_cycle(1'b1, 8'h3C, 3'd2, 1'b0, '0, '0, 1'b1);
    held_d = resp_data; held_id = resp_id;
    total_cnt++; if (held_d !== 8'h0F) $display("FAIL bp_load got=%h exp=0f", held_d); else pass_cnt++;
    for (int k = 0; k < 3; k++) begin
      model_step(1'b1, 8'h11, 3'd1, 1'b1, 8'h22, 3'd1, 1'b0);
      drive_cycle(1'b1, 8'h11, 3'd1, 1'b1, 8'h22, 3'd1, 1'b0);
      total_cnt++; if ({obs_r1, obs_r0} !== 2'b00) $display("FAIL bp_ready[%0d] got=%b exp=00", k, {obs_r1, obs_r0}); else pass_cnt++;
      total_cnt++; if (resp_data !== 8'h0F || resp_id !== 1'b0 || resp_valid !== 1'b1) $display("FAIL bp_hold[%0d] got=%h/%b/%b exp=0f/0/1", k, resp_data, resp_id, resp_valid); else pass_cnt++;
    end
    model_step(1'b1, 8'h11, 3'd1, 1'b1, 8'h22, 3'd1, 1'b1);
    drive_cycle(1'b1, 8'h11, 3'd1, 1'b1, 8'h22, 3'd1, 1'b1);
    total_cnt++; if ({obs_r1, obs_r0} !== 2'b10) $display("FAIL bp_release_ready got=%b exp=10", {obs_r1, obs_r0}); else pass_cnt++;
    total_cnt++; if (resp_data !== 8'h11 || resp_id !== 1'b1) $display("FAIL bp_release_data got=%h/%b exp=11/1", resp_data, resp_id); else pass_cnt++;
  endtask

  task automatic test_random();
    logic       p0v, p1v, rr;
    logic [7:0] p0d, p1d;
    logic [2:0] p0a, p1a;
    int unsigned errs;
    do_reset();
    p0v = 1'b0; p1v = 1'b0; p0d = '0; p1d = '0; p0a = '0; p1a = '0;
    for (int k = 0; k < 300; k++) begin
      if (!p0v && ($urandom_range(0, 3) != 0)) begin p0v = 1'b1; p0d = 8'($urandom); p0a = 3'($urandom); end
      if (!p1v && ($urandom_range(0, 3) != 0)) begin p1v = 1'b1; p1d = 8'($urandom); p1a = 3'($urandom); end
      rr = ($urandom_range(0, 3) != 0);
      model_step(p0v, p0d, p0a, p1v, p1d, p1a, rr);
      drive_cycle(p0v, p0d, p0a, p1v, p1d, p1a, rr);
      errs = 0;
      if ({obs_r1, obs_r0} !== {exp_r1, exp_r0}) errs++;
      if (resp_valid !== m_valid) errs++;
      if (m_valid && (resp_data !== m_data || resp_id !== m_id)) errs++;
      total_cnt++;
      if (errs != 0) $display("FAIL random[%0d] got rdy=%b v=%b d=%h id=%b exp rdy=%b v=%b d=%h id=%b", k, {obs_r1, obs_r0}, resp_valid, resp_data, resp_id, {exp_r1, exp_r0}, m_valid, m_data, m_id);
      else pass_cnt++;
      if (exp_r0) p0v = 1'b0;
      if (exp_r1) p1v = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    model_step(1'b0, '0, '0, 1'b1, 8'hF0, 3'd4, 1'b1);
    drive_cycle(1'b0, '0, '0, 1'b1, 8'hF0, 3'd4, 1'b1);
    total_cnt++; if (resp_valid !== 1'b1 || resp_data !== 8'h0F) $display("FAIL mid_load got=%b/%h exp=1/0f", resp_valid, resp_data); else pass_cnt++;
    req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b0;
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    total_cnt++; if (resp_valid !== 1'b0) $display("FAIL mid_async_valid got=%b exp=0", resp_valid); else pass_cnt++;
    resp_ready = 1'b1;
    #1;
    total_cnt++; if ({req1_ready, req0_ready} !== 2'b00) $display("FAIL mid_ready got=%b exp=00", {req1_ready, req0_ready}); else pass_cnt++;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    model_step(1'b1, 8'h01, 3'd1, 1'b1, 8'h02, 3'd1, 1'b1);
    drive_cycle(1'b1, 8'h01, 3'd1, 1'b1, 8'h02, 3'd1, 1'b1);
    total_cnt++; if ({obs_r1, obs_r0} !== 2'b01) $display("FAIL mid_first_grant got=%b exp=01", {obs_r1, obs_r0}); else pass_cnt++;
    total_cnt++; if (resp_data !== 8'h80 || resp_id !== 1'b0) $display("FAIL mid_first_data got=%h/%b exp=80/0", resp_data, resp_id); else pass_cnt++;
  endtask

`ifdef SHIFTER_ARBITER_STATS_EN
  task automatic test_stats();
    do_reset();
    for (int k = 0; k < 5; k++) drive_cycle(1'b1, 8'h55, 3'd1, 1'b0, '0, '0, 1'b1);
    for (int k = 0; k < 3; k++) drive_cycle(1'b0, '0, '0, 1'b1, 8'h66, 3'd2, 1'b1);
    for (int k = 0; k < 2; k++) drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    total_cnt++; if (gnt0_cnt !== 16'd5) $display("FAIL stats_gnt0 got=%0d exp=5", gnt0_cnt); else pass_cnt++;
    total_cnt++; if (gnt1_cnt !== 16'd3) $display("FAIL stats_gnt1 got=%0d exp=3", gnt1_cnt); else pass_cnt++;
    total_cnt++; if (stall_cnt !== 16'd2) $display("FAIL stats_stall got=%0d exp=2", stall_cnt); else pass_cnt++;
    do_reset();
    total_cnt++; if (gnt0_cnt !== 16'd0) $display("FAIL stats_reset got=%0d exp=0", gnt0_cnt); else pass_cnt++;
    req0_valid = 1'b1; req1_valid = 1'b0; resp_ready = 1'b1;
    repeat (65540) @(posedge clk);
    #1;
    total_cnt++; if (gnt0_cnt !== 16'hFFFF) $display("FAIL stats_sat got=%h exp=ffff", gnt0_cnt); else pass_cnt++;
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_single_ops();
    test_round_robin();
    test_backpressure();
    test_random();
    test_reset_mid();
`ifdef SHIFTER_ARBITER_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
